fp_div_round: RTL

Post-divide rounding stage for the double-precision divider datapath. It takes the raw, unrounded quotient that the divider produces: sign, wide biased exponent, and a 56-bit mantissa with guard/round/sticky bits. It denormalises, rounds per IEEE 754, detects overflow and underflow, and packs the final 64-bit result. It is a 2-stage valid/ready pipeline and also keeps a sticky exception-flag register.

---
 rtl/fp_round_pkg.sv | 42 ++++
 rtl/fp_denorm_shift.sv | 22 ++
 rtl/fp_div_round.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fp_round_pkg.sv
// Shared definitions for the divider rounding stage: rounding modes,
// exception flag positions, binary64 constants and the round-increment rule.
package fp_round_pkg;

  localparam int BIAS      = 1023;
  localparam int EXP_MAX   = 2047;
  localparam int MAX_SHIFT = 58;

  localparam logic [63:0] QNAN       = 64'h7FF8000000000000;
  localparam logic [63:0] POS_INF    = 64'h7FF0000000000000;
  localparam logic [63:0] MAX_FINITE = 64'h7FEFFFFFFFFFFFFF;

  // Flag vector layout is {NV, DZ, OF, UF, NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RUP = 2'b10,
    RND_RDN = 2'b11
  } rnd_mode_e;

  // Decide whether the kept mantissa must be incremented by one ulp.
  // l is the lsb of the kept fraction, g/r/s are the discarded bits.
  function automatic logic round_inc(input rnd_mode_e mode, input logic sign,
                                     input logic l, input logic g,
                                     input logic r, input logic s);
    logic inc;
    case (mode)
      RND_RNE: inc = g & (r | s | l);
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = ~sign & (g | r | s);
      default: inc = sign & (g | r | s);
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fp_denorm_shift.sv
// Right shift of the 56-bit quotient mantissa; every bit shifted out is
// OR-ed into bit 0 so the sticky information survives denormalisation.
module fp_denorm_shift (
  input  logic [55:0] mant_i,
  input  logic [5:0]  shamt_i,
  output logic [55:0] mant_o
);

  logic [55:0] shifted;
  logic [55:0] lost_mask;
  logic        lost;

  // Shift amounts of 56 and above wrap the mask to all ones, so the whole
  // mantissa collapses into the sticky bit as intended.
  always_comb begin
    shifted   = mant_i >> shamt_i;
    lost_mask = (56'd1 << shamt_i) - 56'd1;
    lost      = |(mant_i & lost_mask);
    mant_o    = shifted | {55'd0, lost};
  end

endmodule

// File: rtl/fp_div_round.sv
// Post-divide rounding stage for binary64: S1 denormalises tiny quotients,
// S2 rounds, detects overflow/underflow and packs the result. A sticky
// exception-flag register accumulates the flags of every delivered result.
// Optional feature macro: FPDIV_RND_MODES_EN (all four rounding modes);
// without it rounding is always round-to-nearest-even.
module fp_div_round
  import fp_round_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [12:0] in_exp,
  input  logic [55:0] in_mant,
  input  logic        in_special,
  input  logic [63:0] in_special_val,
  input  logic [4:0]  in_special_flags,
  input  logic [1:0]  rnd_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_flags,
  input  logic        flags_clr,
  output logic [4:0]  sticky_flags
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, ready may depend on the
  // downstream ready, and held data stays stable while valid & !ready.

  rnd_mode_e mode_in;
`ifdef FPDIV_RND_MODES_EN
  assign mode_in = rnd_mode_e'(rnd_mode);
`else
  logic unused_rnd_mode;
  assign mode_in         = RND_RNE;
  assign unused_rnd_mode = ^rnd_mode;
`endif

  // Stage 1 registers
  logic        s1_valid_q;
  logic        s1_sign_q,    s1_sign_d;
  logic [11:0] s1_exp_q,     s1_exp_d;
  logic [55:0] s1_mant_q,    s1_mant_d;
  logic        s1_tiny_q,    s1_tiny_d;
  logic        s1_special_q;
  logic [63:0] s1_sval_q;
  logic [4:0]  s1_sflags_q;
  rnd_mode_e   s1_mode_q;

  // Stage 2 (output) registers
  logic        s2_valid_q;
  logic [63:0] result_q, result_d;
  logic [4:0]  flags_q,  flags_d;
  logic [4:0]  sticky_q, sticky_d;

  logic        s2_en;
  logic        accept;
  logic        exp_le0;
  logic [13:0] sh_wide;
  logic [5:0]  shamt;
  logic [55:0] mant_shifted;

  assign s2_en    = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_en;
  assign accept   = in_valid & in_ready;

  assign out_valid    = s2_valid_q;
  assign out_result   = result_q;
  assign out_flags    = flags_q;
  assign sticky_flags = sticky_q;

  // Shift distance for a non-positive exponent, saturated at MAX_SHIFT
  always_comb begin
    exp_le0 = in_exp[12] | (in_exp == 13'd0);
    sh_wide = 14'd1 - {in_exp[12], in_exp};
    shamt   = (sh_wide > 14'(MAX_SHIFT)) ? 6'(MAX_SHIFT) : sh_wide[5:0];
  end

  fp_denorm_shift u_denorm (
    .mant_i  (in_mant),
    .shamt_i (shamt),
    .mant_o  (mant_shifted)
  );

  // S1 next state: subnormal results get exponent 0 and the tiny marker
  always_comb begin
    s1_sign_d = in_sign;
    s1_tiny_d = exp_le0;
    s1_exp_d  = exp_le0 ? 12'd0 : in_exp[11:0];
    s1_mant_d = exp_le0 ? mant_shifted : in_mant;
  end

  // S1 register: loads whenever the stage is free or draining into S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      s1_tiny_q    <= 1'b0;
      s1_special_q <= 1'b0;
      s1_sval_q    <= '0;
      s1_sflags_q  <= '0;
      s1_mode_q    <= RND_RNE;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (accept) begin
        s1_sign_q    <= s1_sign_d;
        s1_exp_q     <= s1_exp_d;
        s1_mant_q    <= s1_mant_d;
        s1_tiny_q    <= s1_tiny_d;
        s1_special_q <= in_special;
        s1_sval_q    <= in_special_val;
        s1_sflags_q  <= in_special_flags;
        s1_mode_q    <= mode_in;
      end
    end
  end

  logic        g_bit, r_bit, s_bit, l_bit;
  logic        inc;
  logic        nx;
  logic [53:0] sum;
  logic [12:0] exp_post;
  logic        ovf;
  logic        ovf_inf;

  // S2 rounding, overflow detection and packing
  always_comb begin
    l_bit = s1_mant_q[3];
    g_bit = s1_mant_q[2];
    r_bit = s1_mant_q[1];
    s_bit = s1_mant_q[0];
    nx    = g_bit | r_bit | s_bit;
    inc   = round_inc(s1_mode_q, s1_sign_q, l_bit, g_bit, r_bit, s_bit);
    sum   = {1'b0, s1_mant_q[55:3]} + {53'd0, inc};
    // A subnormal has no integer bit; rounding into it makes exponent 1.
    // A normal that carries out of the integer bit bumps the exponent,
    // and the fraction bits are all zero in that case.
    if (s1_tiny_q) exp_post = {12'd0, sum[52]};
    else           exp_post = {1'b0, s1_exp_q} + {12'd0, sum[53]};
    ovf     = exp_post >= 13'(EXP_MAX);
    ovf_inf = (s1_mode_q == RND_RNE) |
              ((s1_mode_q == RND_RUP) & ~s1_sign_q) |
              ((s1_mode_q == RND_RDN) &  s1_sign_q);

    result_d = '0;
    flags_d  = '0;
    if (s1_special_q) begin
      result_d = s1_sval_q;
      flags_d  = s1_sflags_q;
    end else if (ovf) begin
      result_d = ovf_inf ? {s1_sign_q, POS_INF[62:0]} : {s1_sign_q, MAX_FINITE[62:0]};
      flags_d[FLAG_OF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
    end else begin
      result_d = {s1_sign_q, exp_post[10:0], sum[51:0]};
      flags_d[FLAG_UF] = s1_tiny_q & nx;
      flags_d[FLAG_NX] = nx;
    end
  end

  // S2 register: holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  // Sticky flags: a clear in the same cycle as a transfer keeps that transfer
  always_comb begin
    sticky_d = sticky_q;
    if (flags_clr) sticky_d = '0;
    if (s2_valid_q && out_ready) sticky_d = sticky_d | flags_q;
  end

  // Sticky flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

endmodule
